fp32_multiplier: RTL

- Pipelined IEEE-754 single-precision multiplier; directly upstream of the FP32 adder in the feedforward datapath.
- Forms weight*activation products; its z_data/done feed the adder's x_data/x_rdy.
- Fully pipelined: accepts one operand pair per clock, no backpressure.

---
 rtl/fp32_pkg.sv | 42 ++++
 rtl/fp32_unpack.sv | 38 +++
 rtl/fp32_multiplier.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared FP32 constants, operand classes and field-extract helpers.
// Used by the FP32 multiplier and the downstream FP32 adder.
// Contents:
//   FP32_NAN, FP32_POS_INF  canonical NaN and +Inf encodings
//   FP32_BIAS, EXP_MAX      exponent bias and all-ones exponent field
//   fp32_cls_e              operand class (zero/normal/inf/nan)
//   fp32_kind_e             result kind decided ahead of normalisation
//   fp32_sign/exp/frac      field extractors
package fp32_pkg;

   localparam logic [31:0] FP32_NAN     = 32'h7FC00000;
   localparam logic [31:0] FP32_POS_INF = 32'h7F800000;
   localparam int unsigned FP32_BIAS    = 127;
   localparam int unsigned EXP_MAX      = 255;

   typedef enum logic [1:0] {
      ClsZero,
      ClsNormal,
      ClsInf,
      ClsNan
   } fp32_cls_e;

   typedef enum logic [1:0] {
      KindNormal,
      KindZero,
      KindInf,
      KindNan
   } fp32_kind_e;

   function automatic logic fp32_sign(input logic [31:0] v);
      return v[31];
   endfunction

   function automatic logic [7:0] fp32_exp(input logic [31:0] v);
      return v[30:23];
   endfunction

   function automatic logic [22:0] fp32_frac(input logic [31:0] v);
      return v[22:0];
   endfunction

endpackage

// File: rtl/fp32_unpack.sv
// fp32_unpack: classifies one FP32 operand and returns its fields.
// Subnormals are flushed: an exponent field of 0 always classifies as zero.
// Ports:
//   op_i    [31:0] FP32 operand
//   sign_o         sign bit
//   cls_o          operand class (zero/normal/inf/nan)
//   exp_o   [7:0]  biased exponent field
//   mant_o  [23:0] mantissa with hidden 1 for normals, 0 for zero class
module fp32_unpack
   import fp32_pkg::*;
(
   input  logic [31:0] op_i,
   output logic        sign_o,
   output fp32_cls_e   cls_o,
   output logic [7:0]  exp_o,
   output logic [23:0] mant_o
);

   logic [7:0]  exp_f;
   logic [22:0] frac_f;

   always_comb begin
      exp_f  = fp32_exp(op_i);
      frac_f = fp32_frac(op_i);
      sign_o = fp32_sign(op_i);
      exp_o  = exp_f;
      mant_o = {1'b1, frac_f};
      if (exp_f == 8'd0) begin
         cls_o  = ClsZero;
         mant_o = '0;
      end else if (exp_f == 8'(EXP_MAX)) begin
         cls_o = (frac_f == 23'd0) ? ClsInf : ClsNan;
      end else begin
         cls_o = ClsNormal;
      end
   end

endmodule

// File: rtl/fp32_multiplier.sv
// fp32_multiplier: pipelined IEEE-754 single-precision multiplier, one pair per clock.
// Pair accepted on edge N (x_rdy & y_rdy) gives done/z_data after edge N+3:
//   edge N   : operands captured
//   edge N+1 : S1 unpack/classify registered
//   edge N+2 : S2 24x24 mantissa product and exponent sum registered
//   edge N+3 : S3 normalise/round result registered, done pulses
// Subnormal inputs and outputs flush to signed zero. Default rounding is truncation;
// define FP_MUL_ROUND_NEAREST_EN for round-to-nearest-even.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   x_rdy, y_rdy      operand valids; both high accepts the pair
//   x_data, y_data    FP32 operands
//   z_data            FP32 product, held between results
//   done              one-cycle pulse per new product
module fp32_multiplier
   import fp32_pkg::*;
#(
   parameter int unsigned LATENCY = 3,
   parameter int unsigned FTZ     = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        x_rdy,
   input  logic        y_rdy,
   input  logic [31:0] x_data,
   input  logic [31:0] y_data,
   output logic [31:0] z_data,
   output logic        done
);

   if (LATENCY != 3) begin : gen_latency_check
      $error("fp32_multiplier: only LATENCY = 3 is supported");
   end
   if (FTZ != 1) begin : gen_ftz_check
      $error("fp32_multiplier: only FTZ = 1 is supported");
   end

   // capture stage
   logic        v0_q;
   logic [31:0] x0_q, y0_q;

   // S1
   logic        sx, sy;
   fp32_cls_e   cls_x, cls_y;
   logic [7:0]  ex, ey;
   logic [23:0] mx, my;
   fp32_kind_e  kind1_d;
   logic        v1_q, sign1_q;
   fp32_kind_e  kind1_q;
   logic [7:0]  ex1_q, ey1_q;
   logic [23:0] mx1_q, my1_q;

   // S2
   logic               v2_q, sign2_q;
   fp32_kind_e         kind2_q;
   logic [47:0]        prod2_q;
   logic signed [9:0]  exp2_q;

   // S3
   logic [22:0]        frac3;
   logic signed [9:0]  exp3;
   logic [31:0]        z_d;
   logic               done_q;
   logic [31:0]        z_q;

   fp32_unpack u_unpack_x (
      .op_i   (x0_q),
      .sign_o (sx),
      .cls_o  (cls_x),
      .exp_o  (ex),
      .mant_o (mx)
   );

   fp32_unpack u_unpack_y (
      .op_i   (y0_q),
      .sign_o (sy),
      .cls_o  (cls_y),
      .exp_o  (ey),
      .mant_o (my)
   );

   // Special-case priority: NaN (incl. Inf*0) > Inf > zero.
   always_comb begin
      if (cls_x == ClsNan || cls_y == ClsNan ||
          (cls_x == ClsInf && cls_y == ClsZero) ||
          (cls_x == ClsZero && cls_y == ClsInf)) begin
         kind1_d = KindNan;
      end else if (cls_x == ClsInf || cls_y == ClsInf) begin
         kind1_d = KindInf;
      end else if (cls_x == ClsZero || cls_y == ClsZero) begin
         kind1_d = KindZero;
      end else begin
         kind1_d = KindNormal;
      end
   end

`ifdef FP_MUL_ROUND_NEAREST_EN
   logic        guard3, sticky3, round_up3;
   logic [24:0] mant3;
`else
   logic unused_prod_lo;
   assign unused_prod_lo = ^prod2_q[22:0];
`endif

   always_comb begin
      // Normal operands give a product in [2^46, 2^48).
      if (prod2_q[47]) begin
         frac3 = prod2_q[46:24];
         exp3  = exp2_q + 10'sd1;
      end else begin
         frac3 = prod2_q[45:23];
         exp3  = exp2_q;
      end
`ifdef FP_MUL_ROUND_NEAREST_EN
      guard3    = prod2_q[47] ? prod2_q[23] : prod2_q[22];
      sticky3   = prod2_q[47] ? (|prod2_q[22:0]) : (|prod2_q[21:0]);
      round_up3 = guard3 & (sticky3 | frac3[0]);
      mant3     = {2'b01, frac3} + 25'(round_up3);
      // 1.11..1 + ulp carries into 10.00..0: renormalise.
      if (mant3[24]) begin
         frac3 = '0;
         exp3  = exp3 + 10'sd1;
      end else begin
         frac3 = mant3[22:0];
      end
`endif
      z_d = '0;
      unique case (kind2_q)
         KindNan:  z_d = FP32_NAN;
         KindInf:  z_d = {sign2_q, FP32_POS_INF[30:0]};
         KindZero: z_d = {sign2_q, 31'd0};
         default: begin
            if (exp3 >= $signed(10'(EXP_MAX))) begin
               z_d = {sign2_q, FP32_POS_INF[30:0]};
            end else if (exp3 <= 10'sd0) begin
               z_d = {sign2_q, 31'd0};
            end else begin
               z_d = {sign2_q, exp3[7:0], frac3};
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v0_q    <= 1'b0;
         x0_q    <= '0;
         y0_q    <= '0;
         v1_q    <= 1'b0;
         sign1_q <= 1'b0;
         kind1_q <= KindZero;
         ex1_q   <= '0;
         ey1_q   <= '0;
         mx1_q   <= '0;
         my1_q   <= '0;
         v2_q    <= 1'b0;
         sign2_q <= 1'b0;
         kind2_q <= KindZero;
         prod2_q <= '0;
         exp2_q  <= '0;
         done_q  <= 1'b0;
         z_q     <= '0;
      end else begin
         v0_q <= x_rdy & y_rdy;
         if (x_rdy & y_rdy) begin
            x0_q <= x_data;
            y0_q <= y_data;
         end
         v1_q <= v0_q;
         if (v0_q) begin
            sign1_q <= sx ^ sy;
            kind1_q <= kind1_d;
            ex1_q   <= ex;
            ey1_q   <= ey;
            mx1_q   <= mx;
            my1_q   <= my;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            sign2_q <= sign1_q;
            kind2_q <= kind1_q;
            prod2_q <= 48'(mx1_q) * 48'(my1_q);
            exp2_q  <= $signed({2'b00, ex1_q}) + $signed({2'b00, ey1_q})
                       - $signed(10'(FP32_BIAS));
         end
         done_q <= v2_q;
         if (v2_q) begin
            z_q <= z_d;
         end
      end
   end

   assign z_data = z_q;
   assign done   = done_q;

endmodule
